// File: rtl/frame_write_pkg.sv
// Shared types and gear decode for the downlink frame-write controller.
package frame_write_pkg;

  localparam int PKG_CNT_W = 16;

  // High-speed gears: frames are additionally split into fixed-size segments.
  localparam logic [31:0] GEAR_HS0 = 32'h42;
  localparam logic [31:0] GEAR_HS1 = 32'h43;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_COUNT,
    ST_END_WAIT,
    ST_END_HOLD
  } state_t;

  // Bytes per frame for each gear code; zero marks a gear that never frames.
  function automatic logic [PKG_CNT_W-1:0] gear_frame_len(input logic [31:0] gear);
    logic [PKG_CNT_W-1:0] len;
    case (gear)
      32'h52:                                 len = 16'd48;
      32'h51:                                 len = 16'd20;
      32'h4F, 32'h4E:                         len = 16'd40;
      32'h4D, 32'h4C:                         len = 16'd80;
      32'h4B, 32'h4A:                         len = 16'd160;
      32'h49:                                 len = 16'd320;
      32'h48, 32'h47, 32'h46, 32'h45, 32'h44: len = 16'd160;
      32'h43:                                 len = 16'd320;
      32'h42, 32'h41:                         len = 16'd480;
      default:                                len = '0;
    endcase
    return len;
  endfunction

  function automatic logic gear_is_hs(input logic [31:0] gear);
    return (gear == GEAR_HS0) || (gear == GEAR_HS1);
  endfunction

endpackage

// File: rtl/frame_write_ctrl_gear_sync.sv
// Two-flop gear sampler with change detect and a one-cycle FIFO reset
// issued in the cycle after a change is seen.
module gear_sync
  import frame_write_pkg::*;
#(
  parameter int GEAR_W = 8
) (
  input  logic              clk163m84,
  input  logic              rst_n,
  input  logic [GEAR_W-1:0] gear_i,
  output logic [GEAR_W-1:0] gear_q2,
  output logic              gear_chg,
  output logic              fifo_rst
);

  logic [GEAR_W-1:0] gear_q1;

  // A change is visible for exactly one cycle, while q1 has moved and q2 has not.
  assign gear_chg = (gear_q1 != gear_q2);

  // Sample the quasi-static gear and register the FIFO reset pulse.
  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      gear_q1  <= '0;
      gear_q2  <= '0;
      fifo_rst <= 1'b0;
    end else begin
      gear_q1  <= gear_i;
      gear_q2  <= gear_q1;
      fifo_rst <= gear_chg;
    end
  end

endmodule

// File: rtl/frame_write_ctrl.sv
// Frame-write controller: gates source bytes into the downlink FIFO, counts
// them against the per-gear frame length and emits frame/segment pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | counters cleared, wait for a framed gear after FIFO reset
// ST_SYNC     | one settling cycle before accepting bytes
// ST_COUNT    | bytes accepted into the FIFO and counted
// ST_END_WAIT | delay from last byte to the frame_end pulse
// ST_END_HOLD | guard time after frame_end before the next frame
module frame_write_ctrl
  import frame_write_pkg::*;
#(
  parameter int GEAR_W   = 8,
  parameter int CNT_W    = 16,
  parameter int SEG_LEN  = 160,
  parameter int END_DLY  = 7,
  parameter int HOLD_DLY = 7,
  parameter int DROP_W   = 8
) (
  input  logic              clk163m84,
  input  logic              rst_n,
  input  logic [GEAR_W-1:0] gear_i,
  input  logic              data_valid,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic              frame_end,
  output logic              seg_end,
  output logic              fifo_rst,
  output logic              hs_mode,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SEG_LAST = CNT_W'(SEG_LEN);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
  localparam logic [3:0]        END_LAST  = 4'(END_DLY);
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_DLY);

  state_t            state, state_nxt;
  logic [GEAR_W-1:0] gear_q2;
  logic              gear_chg;
  logic [CNT_W-1:0]  frame_len;
  logic [CNT_W-1:0]  byte_cnt, seg_cnt;
  logic [CNT_W-1:0]  byte_cnt_inc, seg_cnt_inc;
  logic [3:0]        dly;
  logic              last_byte, seg_hit;

  gear_sync #(.GEAR_W(GEAR_W)) u_gear_sync (
    .clk163m84 (clk163m84),
    .rst_n     (rst_n),
    .gear_i    (gear_i),
    .gear_q2   (gear_q2),
    .gear_chg  (gear_chg),
    .fifo_rst  (fifo_rst)
  );

  assign byte_cnt_inc = byte_cnt + CNT_ONE;
  assign seg_cnt_inc  = seg_cnt + CNT_ONE;
  // A gear change overrides any byte accepted in the same cycle.
  assign last_byte    = wr_en && !gear_chg && (byte_cnt_inc == frame_len);
  assign seg_hit      = hs_mode && wr_en && !gear_chg &&
                        ((seg_cnt_inc == SEG_LAST) || (byte_cnt_inc == frame_len));

  // State register.
  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a gear change aborts any frame in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // Hold off while the gear or frame length is still settling after a change.
        if (gear_q2 != '0 && frame_len != '0 && !fifo_rst && !gear_chg)
          state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        state_nxt = gear_chg ? ST_IDLE : ST_COUNT;
      end
      ST_COUNT: begin
        if (gear_chg)       state_nxt = ST_IDLE;
        else if (last_byte) state_nxt = ST_END_WAIT;
      end
      ST_END_WAIT: begin
        if (gear_chg)              state_nxt = ST_IDLE;
        else if (dly == END_LAST)  state_nxt = ST_END_HOLD;
      end
      ST_END_HOLD: begin
        if (gear_chg || dly == HOLD_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs; frame_end is suppressed if a gear change lands on it.
  always_comb begin
    wr_en     = data_valid && (state == ST_COUNT) && !fifo_full;
    frame_end = (state == ST_END_WAIT) && (dly == END_LAST) && !gear_chg;
    busy      = (state != ST_IDLE);
  end

  // Counters, delay timer, gear decode and registered pulses.
  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      frame_len <= '0;
      hs_mode   <= 1'b0;
      byte_cnt  <= '0;
      seg_cnt   <= '0;
      dly       <= '0;
      seg_end   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      frame_len <= CNT_W'(gear_frame_len(32'(gear_q2)));
      hs_mode   <= gear_is_hs(32'(gear_q2));
      seg_end   <= 1'b0;

      if (fifo_rst)
        drop_cnt <= '0;
      else if (state == ST_COUNT && data_valid && fifo_full && drop_cnt != {DROP_W{1'b1}})
        drop_cnt <= drop_cnt + DROP_ONE;

      case (state)
        ST_COUNT: begin
          dly <= '0;
          if (wr_en && !gear_chg) begin
            byte_cnt <= byte_cnt_inc;
            if (hs_mode) seg_cnt <= seg_hit ? '0 : seg_cnt_inc;
            seg_end <= seg_hit;
          end
        end
        ST_END_WAIT: begin
          dly <= (dly == END_LAST) ? 4'd0 : dly + 4'd1;
        end
        ST_END_HOLD: begin
          dly <= dly + 4'd1;
        end
        default: begin
          byte_cnt <= '0;
          seg_cnt  <= '0;
          dly      <= '0;
        end
      endcase
    end
  end

endmodule
